// File: rtl/gfx_blend_pkg.sv
// ---------------------------------------------------------------------------
// gfx_blend_pkg
// Shared types and helpers for the per-pixel blend stage.
//   blend_mode_e  : PASS, SRC_OVER, ADD_SAT, MUL (matches blend_mode_i encoding)
//   blend_state_e : transaction FSM states
//   blend_alpha() : effective alpha a' on AW+1 bits (supports AW up to 16)
// ---------------------------------------------------------------------------
package gfx_blend_pkg;

   typedef enum logic [1:0] {
      PASS     = 2'd0,
      SRC_OVER = 2'd1,
      ADD_SAT  = 2'd2,
      MUL      = 2'd3
   } blend_mode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALPHA = 3'd1,
      READ  = 3'd2,
      BLEND = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } blend_state_e;

   // a = (alpha*global)>>aw, a' = a + a[aw-1]. The truncating product can
   // never reach 2^aw, so full-scale alpha times full-scale global is
   // mapped explicitly to 2^aw to make fully opaque fragments detectable.
   function automatic logic [16:0] blend_alpha(input logic [15:0] alpha,
                                               input logic [15:0] global_alpha,
                                               input int unsigned aw);
      logic [31:0] max_v;
      logic [31:0] prod_v;
      logic [31:0] a_v;
      max_v  = (32'd1 << aw) - 32'd1;
      prod_v = 32'(alpha) * 32'(global_alpha);
      a_v    = prod_v >> aw;
      if ((32'(alpha) == max_v) && (32'(global_alpha) == max_v)) begin
         return 17'(32'd1 << aw);
      end else begin
         return 17'(a_v + ((a_v >> (aw - 32'd1)) & 32'd1));
      end
   endfunction

endpackage

// File: rtl/gfx_blend_channel.sv
// ---------------------------------------------------------------------------
// gfx_blend_channel
// Combinational arithmetic for one colour channel, all blend modes.
//   mode   in  blend mode
//   alpha  in  effective alpha a' (AW+1 bits, 0..2^AW)
//   width  in  channel width w (already clamped to CW)
//   mask   in  2^w-1
//   src    in  source field, dst in destination field (both masked)
//   result out blended field, masked to w bits
// ---------------------------------------------------------------------------
module gfx_blend_channel
   import gfx_blend_pkg::*;
#(
   parameter int CW = 10,
   parameter int AW = 8
) (
   input  blend_mode_e     mode,
   input  logic [AW:0]     alpha,
   input  logic [3:0]      width,
   input  logic [CW-1:0]   mask,
   input  logic [CW-1:0]   src,
   input  logic [CW-1:0]   dst,
   output logic [CW-1:0]   result
);

   localparam int PW = CW + AW + 2;
   localparam int MW = 2 * CW + 1;
   localparam logic [AW:0] ALPHA_FULL = {1'b1, {AW{1'b0}}};

   logic [PW-1:0] sa_s;
   logic [PW-1:0] over_s;
   logic [PW-1:0] add_s;
   logic [CW-1:0] add_sat_s;
   logic [AW:0]   inv_alpha_s;
   logic [CW-1:0] dst_sh_s;
   logic          d_msb_s;
   logic [CW:0]   d_rnd_s;
   logic [MW-1:0] mul_s;
   logic [CW-1:0] res_s;

   // Per-mode arithmetic and mode select
   always_comb begin
      sa_s        = PW'(src) * PW'(alpha);
      inv_alpha_s = ALPHA_FULL - alpha;
      over_s      = (sa_s + PW'(dst) * PW'(inv_alpha_s)) >> AW;
      add_s       = PW'(dst) + (sa_s >> AW);
      if (add_s > PW'(mask)) begin
         add_sat_s = mask;
      end else begin
         add_sat_s = add_s[CW-1:0];
      end
      // d + d[w-1] lets a full-scale destination act as 2^w in the product
      dst_sh_s = (width == 4'd0) ? {CW{1'b0}} : (dst >> (width - 4'd1));
      d_msb_s  = dst_sh_s[0];
      d_rnd_s  = {1'b0, dst} + {{CW{1'b0}}, d_msb_s};
      mul_s    = (MW'(src) * MW'(d_rnd_s)) >> width;
      case (mode)
         SRC_OVER: res_s = over_s[CW-1:0];
         ADD_SAT:  res_s = add_sat_s;
         MUL:      res_s = mul_s[CW-1:0];
         default:  res_s = src;
      endcase
      result = res_s & mask;
   end

endmodule

// File: rtl/gfx_blend_unit.sv
// ---------------------------------------------------------------------------
// gfx_blend_unit
// Per-pixel blend stage between fragment processor and renderer. Latches a
// fragment in IDLE, optionally reads the target pixel, blends per channel and
// issues one write to the renderer, then pulses ack_o.
//   clk_i, rst_i (async, active-high)
//   write_i, x/y/z, pixel_color_i, alpha_i, global_alpha_i,
//   blending_enable_i, blend_mode_i, color_comp_i : fragment in
//   ack_o                                          : fragment done pulse
//   target_request_o / target_ack_i / target_color_i / wbm_busy_i : target read
//   pixel_x/y/z_o, pixel_color_o, write_o / ack_i  : renderer write
// ---------------------------------------------------------------------------
module gfx_blend_unit
   import gfx_blend_pkg::*;
#(
   parameter int point_width = 16,
   parameter int NCH         = 3,
   parameter int CW          = 10,
   parameter int AW          = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          blending_enable_i,
   input  logic [1:0]                    blend_mode_i,
   input  logic [4*NCH-1:0]              color_comp_i,
   input  logic                          write_i,
   input  logic [point_width-1:0]        x_counter_i,
   input  logic [point_width-1:0]        y_counter_i,
   input  logic signed [point_width-1:0] z_i,
   input  logic [31:0]                   pixel_color_i,
   input  logic [AW-1:0]                 alpha_i,
   input  logic [AW-1:0]                 global_alpha_i,
   output logic                          ack_o,
   output logic                          target_request_o,
   input  logic                          target_ack_i,
   input  logic [31:0]                   target_color_i,
   input  logic                          wbm_busy_i,
   output logic [point_width-1:0]        pixel_x_o,
   output logic [point_width-1:0]        pixel_y_o,
   output logic signed [point_width-1:0] pixel_z_o,
   output logic [31:0]                   pixel_color_o,
   output logic                          write_o,
   input  logic                          ack_i
);

   localparam int SW = 6;
   localparam logic [AW:0] ALPHA_FULL = {1'b1, {AW{1'b0}}};

   blend_state_e  state_r, state_s;
   blend_mode_e   mode_r;
   logic [31:0]   src_r, dst_r, blend_s;
   logic [AW-1:0] alpha_r, global_r;
   logic [AW:0]   alpha_eff_r, alpha_eff_s;
   logic          write_s, ack_s, req_s;
   logic          pass_s, opaque_s, clear_s, tack_s;
   logic [3:0]    width_r [NCH];
   logic [3:0]    width_s [NCH];
   logic [CW-1:0] mask_r  [NCH];
   logic [CW-1:0] mask_s  [NCH];
   logic [SW-1:0] shift_r [NCH];
   logic [SW-1:0] shift_s [NCH];
   logic [SW-1:0] shift_acc_s;
   logic [CW-1:0] src_field_s [NCH];
   logic [CW-1:0] dst_field_s [NCH];
   logic [CW-1:0] res_s       [NCH];

   assign pass_s      = !blending_enable_i || (blend_mode_i == 2'd0);
   assign alpha_eff_s = (AW+1)'(blend_alpha(16'(alpha_r), 16'(global_r), AW));
   assign opaque_s    = (mode_r == SRC_OVER) && (alpha_eff_s == ALPHA_FULL);
   assign clear_s     = (mode_r == SRC_OVER) && (alpha_eff_s == {(AW+1){1'b0}});
   assign tack_s      = target_request_o && target_ack_i;

   // Channel width clamp, mask and bit offset from the component nibbles
   always_comb begin
      shift_acc_s = {SW{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         if (color_comp_i[4*k +: 4] > 4'(CW)) begin
            width_s[k] = 4'(CW);
         end else begin
            width_s[k] = color_comp_i[4*k +: 4];
         end
         mask_s[k]   = CW'((32'd1 << width_s[k]) - 32'd1);
         shift_s[k]  = shift_acc_s;
         shift_acc_s = shift_acc_s + SW'(width_s[k]);
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign src_field_s[k] = CW'(src_r >> shift_r[k]) & mask_r[k];
      assign dst_field_s[k] = CW'(dst_r >> shift_r[k]) & mask_r[k];
      gfx_blend_channel #(.CW(CW), .AW(AW)) u_ch (
         .mode   (mode_r),
         .alpha  (alpha_eff_r),
         .width  (width_r[k]),
         .mask   (mask_r[k]),
         .src    (src_field_s[k]),
         .dst    (dst_field_s[k]),
         .result (res_s[k])
      );
   end

   // Reassemble channel results; bits above the last channel stay zero
   always_comb begin
      blend_s = 32'd0;
      for (int k = 0; k < NCH; k++) begin
         blend_s = blend_s | (32'(res_s[k]) << shift_r[k]);
      end
   end

   // Next state and next handshake outputs
   always_comb begin
      state_s = state_r;
      write_s = write_o;
      ack_s   = 1'b0;
      req_s   = target_request_o;
      case (state_r)
         IDLE: begin
            if (write_i) begin
               state_s = pass_s ? WRITE : ALPHA;
            end else begin
               state_s = IDLE;
            end
         end
         ALPHA: begin
            if (opaque_s) begin
               state_s = WRITE;
            end else if (clear_s) begin
               state_s = DONE;
            end else begin
               state_s = READ;
            end
         end
         READ: begin
            if (tack_s) begin
               req_s   = 1'b0;
               state_s = BLEND;
            end else begin
               req_s   = !wbm_busy_i || target_request_o;
               state_s = READ;
            end
         end
         BLEND: state_s = WRITE;
         WRITE: begin
            if (write_o && ack_i) begin
               write_s = 1'b0;
               state_s = DONE;
            end else begin
               write_s = 1'b1;
               state_s = WRITE;
            end
         end
         DONE: begin
            ack_s   = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            write_s = 1'b0;
            req_s   = 1'b0;
         end
      endcase
   end

   // State register and handshake outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r          <= IDLE;
         write_o          <= 1'b0;
         ack_o            <= 1'b0;
         target_request_o <= 1'b0;
      end else begin
         state_r          <= state_s;
         write_o          <= write_s;
         ack_o            <= ack_s;
         target_request_o <= req_s;
      end
   end

   // Fragment latch and colour datapath
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mode_r        <= PASS;
         src_r         <= 32'd0;
         dst_r         <= 32'd0;
         alpha_r       <= {AW{1'b0}};
         global_r      <= {AW{1'b0}};
         alpha_eff_r   <= {(AW+1){1'b0}};
         pixel_x_o     <= {point_width{1'b0}};
         pixel_y_o     <= {point_width{1'b0}};
         pixel_z_o     <= {point_width{1'b0}};
         pixel_color_o <= 32'd0;
         for (int k = 0; k < NCH; k++) begin
            width_r[k] <= 4'd0;
            mask_r[k]  <= {CW{1'b0}};
            shift_r[k] <= {SW{1'b0}};
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (write_i) begin
                  mode_r    <= pass_s ? PASS : blend_mode_e'(blend_mode_i);
                  src_r     <= pixel_color_i;
                  alpha_r   <= alpha_i;
                  global_r  <= global_alpha_i;
                  pixel_x_o <= x_counter_i;
                  pixel_y_o <= y_counter_i;
                  pixel_z_o <= z_i;
                  for (int k = 0; k < NCH; k++) begin
                     width_r[k] <= width_s[k];
                     mask_r[k]  <= mask_s[k];
                     shift_r[k] <= shift_s[k];
                  end
                  if (pass_s) begin
                     pixel_color_o <= pixel_color_i;
                  end
               end
            end
            ALPHA: begin
               alpha_eff_r <= alpha_eff_s;
               if (opaque_s) begin
                  pixel_color_o <= src_r;
               end
            end
            READ: begin
               if (tack_s) begin
                  dst_r <= target_color_i;
               end
            end
            BLEND: pixel_color_o <= blend_s;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_blend_unit.sv
// ---------------------------------------------------------------------------
// tb_gfx_blend_unit
// Scoreboard bench for gfx_blend_unit: expected write data is queued when a
// fragment is driven and popped when write_o appears.
// ---------------------------------------------------------------------------
module tb_gfx_blend_unit;

   typedef struct {
      logic [31:0] color;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               blending_enable;
   logic [1:0]         blend_mode;
   logic [11:0]        color_comp;
   logic               write_in;
   logic [15:0]        x_counter, y_counter;
   logic signed [15:0] z_in;
   logic [31:0]        pixel_color_in;
   logic [7:0]         alpha, global_alpha;
   logic               ack_out, target_request, target_ack, wbm_busy;
   logic [31:0]        target_color;
   logic [15:0]        pixel_x, pixel_y;
   logic signed [15:0] pixel_z;
   logic [31:0]        pixel_color_out;
   logic               write_out, ack_in;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   gfx_blend_unit dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .blending_enable_i (blending_enable),
      .blend_mode_i      (blend_mode),
      .color_comp_i      (color_comp),
      .write_i           (write_in),
      .x_counter_i       (x_counter),
      .y_counter_i       (y_counter),
      .z_i               (z_in),
      .pixel_color_i     (pixel_color_in),
      .alpha_i           (alpha),
      .global_alpha_i    (global_alpha),
      .ack_o             (ack_out),
      .target_request_o  (target_request),
      .target_ack_i      (target_ack),
      .target_color_i    (target_color),
      .wbm_busy_i        (wbm_busy),
      .pixel_x_o         (pixel_x),
      .pixel_y_o         (pixel_y),
      .pixel_z_o         (pixel_z),
      .pixel_color_o     (pixel_color_out),
      .write_o           (write_out),
      .ack_i             (ack_in)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_alpha(input int al, input int gl);
      int a;
      if (al == 255 && gl == 255) return 256;
      a = (al * gl) >> 8;
      return a + ((a >> 7) & 1);
   endfunction

   function automatic logic [31:0] model_blend(input int mode, input logic [11:0] comp,
                                               input logic [31:0] src, input logic [31:0] dst,
                                               input int ap);
      logic [31:0] r;
      int sh, w, m, s, d, dr, v;
      r  = 32'd0;
      sh = 0;
      for (int k = 0; k < 3; k++) begin
         w = int'(comp[4*k +: 4]);
         if (w > 10) w = 10;
         m = (1 << w) - 1;
         s = int'((src >> sh) & 32'(m));
         d = int'((dst >> sh) & 32'(m));
         case (mode)
            1: v = (s * ap + d * (256 - ap)) >> 8;
            2: begin
               v = d + ((s * ap) >> 8);
               if (v > m) v = m;
            end
            3: begin
               dr = d + ((w > 0) ? ((d >> (w - 1)) & 1) : 0);
               v  = (s * dr) >> w;
            end
            default: v = s;
         endcase
         r  = r | (32'(v & m) << sh);
         sh = sh + w;
      end
      return r;
   endfunction

   task automatic run_frag(input logic en, input logic [1:0] mode, input logic [11:0] comp,
                           input logic [31:0] src, input logic [31:0] dst,
                           input logic [7:0] al, input logic [7:0] gl,
                           input logic [31:0] exp_color, input int busy_cyc, input bit abort);
      int   ap, reads, writes, req_seen, first_req, tack_edge, write_cyc, done_cyc, exp_req;
      bit   exp_read, exp_write, done, tack_prev, ack_prev;
      exp_t e, got;
      ap        = model_alpha(int'(al), int'(gl));
      exp_read  = en && (mode != 2'd0) && !((mode == 2'd1) && (ap == 0 || ap == 256));
      exp_write = !(en && (mode == 2'd1) && (ap == 0));
      exp_req   = (busy_cyc > 2) ? busy_cyc : 2;
      e.color = exp_color;
      e.x = 16'($urandom);
      e.y = 16'($urandom);
      e.z = 16'($urandom);
      if (exp_write && !abort) sb_q.push_back(e);
      reads = 0; writes = 0; req_seen = 0;
      first_req = -1; tack_edge = -1; write_cyc = -1; done_cyc = -1;
      done = 1'b0; tack_prev = 1'b0; ack_prev = 1'b0;
      write_in        = 1'b1;
      blending_enable = en;
      blend_mode      = mode;
      color_comp      = comp;
      pixel_color_in  = src;
      alpha           = al;
      global_alpha    = gl;
      x_counter       = e.x;
      y_counter       = e.y;
      z_in            = e.z;
      wbm_busy        = (busy_cyc > 0);
      @(negedge clk);
      // fragment was taken at edge 0; upstream may now change everything
      write_in        = 1'b0;
      blending_enable = 1'($urandom);
      blend_mode      = 2'($urandom);
      color_comp      = 12'($urandom);
      pixel_color_in  = $urandom;
      alpha           = 8'($urandom);
      global_alpha    = 8'($urandom);
      x_counter       = 16'($urandom);
      y_counter       = 16'($urandom);
      z_in            = 16'($urandom);
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (tack_prev) begin
            check_val("req_drop", target_request, 1'b0);
            target_ack = 1'b0;
            tack_prev  = 1'b0;
         end else if (target_request) begin
            if (first_req < 0) first_req = cyc;
            if (abort) begin
               rst = 1'b1;
               #1;
               check_val("rst_req", target_request, 1'b0);
               check_val("rst_write", write_out, 1'b0);
               check_val("rst_ack", ack_out, 1'b0);
               check_val("rst_color", pixel_color_out, 32'd0);
               check_val("rst_xyz", {pixel_x, pixel_y, pixel_z}, 48'd0);
               done = 1'b1;
            end else begin
               req_seen++;
               if (req_seen == 2) begin
                  target_ack   = 1'b1;
                  target_color = dst;
                  tack_edge    = cyc + 1;
                  tack_prev    = 1'b1;
                  reads++;
               end
            end
         end
         if (ack_prev) begin
            check_val("write_drop", write_out, 1'b0);
            ack_in   = 1'b0;
            ack_prev = 1'b0;
         end else if (write_out && !abort) begin
            writes++;
            write_cyc = cyc;
            check_val("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
               got = sb_q.pop_front();
               check_val("color", pixel_color_out, got.color);
               check_val("xyz", {pixel_x, pixel_y, pixel_z}, {got.x, got.y, got.z});
            end
            ack_in   = 1'b1;
            ack_prev = 1'b1;
         end
         if (ack_out && !abort) begin
            done_cyc = cyc;
            done     = 1'b1;
         end
         wbm_busy = (cyc + 1 < busy_cyc);
         if (!done) @(negedge clk);
      end
      if (abort) begin
         check_val("abort_req_cycle", first_req, exp_req);
         @(negedge clk);
         rst        = 1'b0;
         target_ack = 1'b0;
         ack_in     = 1'b0;
         wbm_busy   = 1'b0;
         @(negedge clk);
      end else begin
         check_val("ack_o_seen", done_cyc >= 0, 1'b1);
         @(negedge clk);
         check_val("ack_pulse", ack_out, 1'b0);
         check_val("reads", reads, exp_read ? 1 : 0);
         check_val("writes", writes, exp_write ? 1 : 0);
         if (exp_read) begin
            check_val("req_cycle", first_req, exp_req);
            check_val("write_cycle", write_cyc, tack_edge + 2);
         end else if (exp_write) begin
            check_val("write_cycle", write_cyc, (en && mode != 2'd0) ? 2 : 1);
         end
         if (exp_write) begin
            check_val("done_cycle", done_cyc, write_cyc + 2);
         end else begin
            check_val("done_cycle", done_cyc, 2);
         end
      end
   endtask

   initial begin
      logic [11:0] comps [4];
      logic [31:0] s, d, ex;
      logic [7:0]  al, gl;
      int          md, ap;
      comps = '{12'h565, 12'h888, 12'hC5C, 12'h4A4};
      rst = 1'b1; write_in = 1'b0; blending_enable = 1'b0; blend_mode = 2'd0;
      color_comp = 12'd0; x_counter = 16'd0; y_counter = 16'd0; z_in = 16'sd0;
      pixel_color_in = 32'd0; alpha = 8'd0; global_alpha = 8'd0;
      target_ack = 1'b0; target_color = 32'd0; wbm_busy = 1'b0; ack_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("reset_outs", {ack_out, target_request, write_out}, 3'd0);
      check_val("reset_color", pixel_color_out, 32'd0);
      check_val("reset_xyz", {pixel_x, pixel_y, pixel_z}, 48'd0);
      rst = 1'b0;
      @(negedge clk);

      run_frag(1'b1, 2'd1, 12'h565, 32'h0000F800, 32'h0000001F, 8'h80, 8'hFF, 32'h0000780F, 0, 1'b0);
      run_frag(1'b1, 2'd1, 12'h888, 32'h12345678, 32'h00000000, 8'hFF, 8'hFF, 32'h12345678, 0, 1'b0);
      run_frag(1'b1, 2'd1, 12'h888, 32'h00ABCDEF, 32'h00000000, 8'h00, 8'hFF, 32'h00000000, 0, 1'b0);
      run_frag(1'b1, 2'd2, 12'h888, 32'h00808080, 32'h00909090, 8'hFF, 8'hFF, 32'h00FFFFFF, 0, 1'b0);
      run_frag(1'b1, 2'd3, 12'h888, 32'h00FF8000, 32'h0080FF40, 8'h40, 8'h80, 32'h00808000, 5, 1'b0);
      run_frag(1'b1, 2'd0, 12'h888, 32'hDEADBEEF, 32'h00000000, 8'h10, 8'h20, 32'hDEADBEEF, 0, 1'b0);
      run_frag(1'b0, 2'd1, 12'h565, 32'hCAFEF00D, 32'h00000000, 8'h80, 8'hFF, 32'hCAFEF00D, 0, 1'b0);
      run_frag(1'b1, 2'd1, 12'h888, 32'h00112233, 32'h00445566, 8'h80, 8'hFF, 32'h00000000, 0, 1'b1);
      run_frag(1'b1, 2'd0, 12'h565, 32'h13579BDF, 32'h00000000, 8'h00, 8'h00, 32'h13579BDF, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         md = $urandom_range(1, 3);
         s  = $urandom;
         d  = $urandom;
         al = 8'($urandom);
         gl = (i % 3 == 0) ? 8'hFF : 8'($urandom);
         ap = model_alpha(int'(al), int'(gl));
         if (md == 1 && ap == 256) ex = s;
         else ex = model_blend(md, comps[i % 4], s, d, ap);
         run_frag(1'b1, 2'(md), comps[i % 4], s, d, al, gl, ex, $urandom_range(0, 6), 1'b0);
      end

      check_val("sb_final", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
